d4_qam_top: RTL and testbench
=============================

Name: d4_qam_top

Overview:
- Deliverable-4 top level of the 16-QAM transmit chain; sits directly on the board pins.
- Derives the sample clock and symbol clock from the 50 MHz board clock.
- Generates a PRBS symbol stream, maps it to 16-QAM I/Q levels and upsamples it by 4 to the sample rate.
- Exports both derived clocks and the I/Q sample stream for downstream filter/DAC blocks.

Parameters:
- SAM_DIV_LOG2, 2, log2 of clock_50 cycles per sample (sample period = 4 clocks).
- SPS_LOG2, 2, log2 of samples per symbol (symbol period = 16 clocks).
- LFSR_SEED, 22'h3FFFFF, PRBS state loaded on reset.

Ports:
- clock_50  in  1  system clock, 50 MHz; every flop is clocked on its rising edge.
- KEY  in  4  push buttons, active-low. KEY[3] is the reset: asynchronous, active-low, asserted when KEY[3]=0. KEY[2:0] are ignored and may be held at any level.
- sam_clk  out  1  sample clock, clock_50/4, 50% duty.
- sym_clk  out  1  symbol clock, clock_50/16, 50% duty.
- sam_i  out  18  signed 1s17 I sample.
- sam_q  out  18  signed 1s17 Q sample.
- sym_bits  out  4  most recently issued symbol, {Q[1:0], I[1:0]}.

Behaviour:
- Reset (KEY[3]=0), applied immediately and asynchronously:
  - 4-bit divider cnt=0, sam_clk=0, sym_clk=0.
  - sam_i=0, sam_q=0, sym_bits=0, LFSR=LFSR_SEED.
  - Reset may assert at any point, including mid-symbol; all state returns to the values above and resumes cleanly on release.
- Divider:
  - cnt increments by 1 every clock and wraps from 15 to 0.
  - sam_clk is driven directly by flop bit cnt[1]; sym_clk by flop bit cnt[3]. No combinational gating on either clock.
  - Both clocks fall together on the 15->0 wrap.
- Enables (internal logic uses clock enables on clock_50, never the derived clocks):
  - sam_en = (cnt[1:0]==3).
  - sym_en = (cnt==15); it always coincides with a sam_en.
- PRBS source:
  - 22-bit Fibonacci LFSR, polynomial x^22+x^21+1.
  - On sym_en: lfsr <= {lfsr[20:0], lfsr[21]^lfsr[20]}.
  - All-zero state is unreachable from LFSR_SEED; no lock-up recovery is required.
- Mapper:
  - Symbol = lfsr[3:0] taken before the shift; I bits = lfsr[1:0], Q bits = lfsr[3:2].
  - Level map: 00 -> -3/4 (18'h28000), 01 -> -1/4 (18'h38000), 11 -> +1/4 (18'h08000), 10 -> +3/4 (18'h18000).
- Upsampler:
  - On sym_en: sym_bits <= lfsr[3:0], sam_i/sam_q <= mapped levels.
  - On any other sam_en: sam_i/sam_q <= 0 (zero-stuffing).
  - Result: outputs change only at sam_clk falling edges and are stable at sam_clk rising edges.
- Latency:
  - First symbol appears on the clock edge where cnt wraps 15->0, 16 clocks after reset release.
  - One nonzero sample per 4 samples.

Optional Feature:
- Macro: D4_SAMPLE_HOLD_EN.
- Defined: the upsampler holds the symbol levels for all 4 samples of the symbol period (zero-order hold); non-sym_en sam_en cycles leave sam_i/sam_q unchanged.
- Undefined: zero-stuffing as described in Behaviour.

Decomposition:
- Package d4_pkg: sample width 18, LEVEL_P3/P1/M1/M3 constants, LFSR width 22 and seed, divider widths.
- One sub-module d4_prbs22: LFSR with advance enable and 4-bit symbol tap output.
- Divider, mapper and upsampler stay in the top.

Test Plan:
- Reset: clock_50 period 20 ns; KEY[3]=0 from 500 ns to 600 ns, KEY[2:0]=0 throughout -> during reset sam_clk=0, sym_clk=0, sam_i=sam_q=0, sym_bits=0.
- Clock ratios: after release -> sam_clk period 80 ns at 50% duty; sym_clk period 320 ns; both fall on the same clock_50 edge.
- First symbol: 16 clocks after release -> sym_bits=4'hF, sam_i=sam_q=18'h08000; next 3 samples 0 (zero-stuff).
- Second symbol: next sym_en (LFSR=3FFFFE) -> sym_bits=4'hE, sam_i=18'h18000, sam_q=18'h08000.
- Mid-symbol reset: assert KEY[3]=0 at cnt=6 -> all outputs 0 immediately; after release the sequence restarts with sym_bits=4'hF.
- D4_SAMPLE_HOLD_EN defined -> sam_i holds 18'h08000 for 4 consecutive sam_clk periods, then 18'h18000 for the next 4.

Source files
------------

// File: rtl/d4_pkg.sv
// d4_pkg: shared widths, 16-QAM levels and PRBS defaults for the deliverable-4 transmit chain
package d4_pkg;
  localparam int SAM_W = 18;
  localparam int LFSR_W = 22;
  localparam int SAM_DIV_LOG2_DEF = 2;
  localparam int SPS_LOG2_DEF = 2;
  localparam int CNT_W_DEF = SAM_DIV_LOG2_DEF + SPS_LOG2_DEF;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 22'h3FFFFF;
  localparam logic [SAM_W-1:0] LEVEL_P3 = 18'h18000;
  localparam logic [SAM_W-1:0] LEVEL_P1 = 18'h08000;
  localparam logic [SAM_W-1:0] LEVEL_M1 = 18'h38000;
  localparam logic [SAM_W-1:0] LEVEL_M3 = 18'h28000;
  typedef logic [SAM_W-1:0] sample_t;
  function automatic sample_t map_level(input logic [1:0] b);
    return b[1] ? (b[0] ? LEVEL_P1 : LEVEL_P3) : (b[0] ? LEVEL_M1 : LEVEL_M3);
  endfunction
endpackage

// File: rtl/d4_prbs22.sv
// d4_prbs22: x^22+x^21+1 Fibonacci LFSR advanced on enable, low nibble exposed as the symbol tap
module d4_prbs22
  import d4_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output logic [3:0] sym
);
  logic [LFSR_W-1:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= SEED;
    else if (adv) lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};
  assign sym = lfsr[3:0];
endmodule

// File: rtl/d4_qam_top.sv
// d4_qam_top: clock divider, PRBS 16-QAM mapper and x4 upsampler; D4_SAMPLE_HOLD_EN selects zero-order hold over zero-stuffing
module d4_qam_top
  import d4_pkg::*;
#(
  parameter int SAM_DIV_LOG2 = SAM_DIV_LOG2_DEF,
  parameter int SPS_LOG2 = SPS_LOG2_DEF,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic             clock_50,
  input  logic [3:0]       KEY,
  output logic             sam_clk,
  output logic             sym_clk,
  output logic [SAM_W-1:0] sam_i,
  output logic [SAM_W-1:0] sam_q,
  output logic [3:0]       sym_bits
);
  localparam int CNT_W = SAM_DIV_LOG2 + SPS_LOG2;
  logic rst_n, unused_key, sam_en, sym_en;
  logic [CNT_W-1:0] cnt;
  logic [3:0] tap;
  assign rst_n = KEY[3];
  assign unused_key = ^KEY[2:0];
  always_ff @(posedge clock_50 or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt + 1'b1;
  assign sam_clk = cnt[SAM_DIV_LOG2-1];
  assign sym_clk = cnt[CNT_W-1];
  assign sam_en = &cnt[SAM_DIV_LOG2-1:0];
  assign sym_en = &cnt;
  d4_prbs22 #(.SEED(LFSR_SEED)) u_prbs (
    .clk  (clock_50),
    .rst_n(rst_n),
    .adv  (sym_en),
    .sym  (tap)
  );
  always_ff @(posedge clock_50 or negedge rst_n)
    if (!rst_n) begin
      sym_bits <= '0;
      sam_i <= '0;
      sam_q <= '0;
    end else if (sym_en) begin
      sym_bits <= tap;
      sam_i <= map_level(tap[1:0]);
      sam_q <= map_level(tap[3:2]);
    end
`ifndef D4_SAMPLE_HOLD_EN
    else if (sam_en) begin
      sam_i <= '0;
      sam_q <= '0;
    end
`endif
endmodule

// File: tb/tb_d4_qam_top.sv
// tb_d4_qam_top: vector table plus randomized resets checked against a symbol-sequence model of the QAM chain
module tb_d4_qam_top;
`ifdef D4_SAMPLE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic clock_50 = 1'b0;
  logic [3:0] KEY = 4'h8;
  logic sam_clk, sym_clk;
  logic [17:0] sam_i, sam_q;
  logic [3:0] sym_bits;
  int n_cmp = 0, n_bad = 0, n = 0;
  logic [3:0] syms[64];
  real sam_r = 0, sam_r_prev = 0, sam_f = 0, sym_r = 0, sym_r_prev = 0, sym_f = 0;

  d4_qam_top dut (
    .clock_50(clock_50),
    .KEY     (KEY),
    .sam_clk (sam_clk),
    .sym_clk (sym_clk),
    .sam_i   (sam_i),
    .sam_q   (sam_q),
    .sym_bits(sym_bits)
  );

  always #10 clock_50 = ~clock_50;
  always @(posedge sam_clk) begin sam_r_prev = sam_r; sam_r = $realtime; end
  always @(negedge sam_clk) sam_f = $realtime;
  always @(posedge sym_clk) begin sym_r_prev = sym_r; sym_r = $realtime; end
  always @(negedge sym_clk) sym_f = $realtime;

  typedef struct {
    int n;
    logic [3:0] sym;
    logic [17:0] i;
    logic [17:0] q;
    logic sc;
    logic yc;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at n=%0d t=%0t: got %h want %h", name, n, $time, act, exp);
    end
  endtask

  function automatic logic [17:0] lvl(input logic [1:0] b);
    int v;
    v = (b == 2'b00) ? -3 : (b == 2'b01) ? -1 : (b == 2'b11) ? 1 : 3;
    return 18'(v * 32768);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_sam_clk"}, 32'(sam_clk), 32'd0);
    chk({tag, "_sym_clk"}, 32'(sym_clk), 32'd0);
    chk({tag, "_sam_i"}, 32'(sam_i), 32'd0);
    chk({tag, "_sam_q"}, 32'(sam_q), 32'd0);
    chk({tag, "_sym_bits"}, 32'(sym_bits), 32'd0);
  endtask

  task automatic chk_model();
    int c, k;
    logic [3:0] s;
    logic nz;
    c = n % 16;
    k = n / 16;
    s = (k == 0) ? 4'h0 : syms[k-1];
    nz = (k != 0) && (HOLD || c < 4);
    chk("m_sam_clk", 32'(sam_clk), 32'((c / 2) % 2));
    chk("m_sym_clk", 32'(sym_clk), 32'(c / 8));
    chk("m_sym_bits", 32'(sym_bits), 32'(s));
    chk("m_sam_i", 32'(sam_i), nz ? 32'(lvl(s[1:0])) : 32'd0);
    chk("m_sam_q", 32'(sam_q), nz ? 32'(lvl(s[3:2])) : 32'd0);
  endtask

  task automatic step();
    @(posedge clock_50);
    #5;
    n++;
    chk_model();
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic reset_pulse(input string tag, input int hold_cycles);
    KEY = {1'b0, 3'($urandom)};
    #1;
    chk_zero(tag);
    for (int c = 0; c < hold_cycles; c++) @(posedge clock_50);
    #5;
    chk_zero({tag, "_held"});
    KEY = {1'b1, 3'($urandom)};
    n = 0;
  endtask

  initial begin
    logic [21:0] l;
    logic [17:0] z1, z3;
    l = 22'h3FFFFF;
    for (int k = 0; k < 64; k++) begin
      syms[k] = l[3:0];
      l = {l[20:0], l[21] ^ l[20]};
    end
    z1 = HOLD ? 18'h08000 : 18'h0;
    z3 = HOLD ? 18'h18000 : 18'h0;
    tv[0] = '{15, 4'h0, 18'h0, 18'h0, 1'b1, 1'b1};
    tv[1] = '{16, 4'hF, 18'h08000, 18'h08000, 1'b0, 1'b0};
    tv[2] = '{19, 4'hF, 18'h08000, 18'h08000, 1'b1, 1'b0};
    tv[3] = '{20, 4'hF, z1, z1, 1'b0, 1'b0};
    tv[4] = '{26, 4'hF, z1, z1, 1'b1, 1'b1};
    tv[5] = '{32, 4'hE, 18'h18000, 18'h08000, 1'b0, 1'b0};
    tv[6] = '{36, 4'hE, z3, z1, 1'b0, 1'b0};
    tv[7] = '{48, 4'hC, 18'h28000, 18'h08000, 1'b0, 1'b0};

    #500 KEY = 4'h0;
    #50 chk_zero("rst");
    #50 KEY = 4'h8;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      while (n < tv[i].n) step();
      chk("t_sym_bits", 32'(sym_bits), 32'(tv[i].sym));
      chk("t_sam_i", 32'(sam_i), 32'(tv[i].i));
      chk("t_sam_q", 32'(sam_q), 32'(tv[i].q));
      chk("t_sam_clk", 32'(sam_clk), 32'(tv[i].sc));
      chk("t_sym_clk", 32'(sym_clk), 32'(tv[i].yc));
    end
    while (n < 64) step();
    chk("sam_period", 32'(int'(sam_r - sam_r_prev)), 32'd80);
    chk("sam_high", 32'(int'(sam_f - sam_r)), 32'd40);
    chk("sym_period", 32'(int'(sym_r - sym_r_prev)), 32'd320);
    chk("fall_align", 32'(int'(sym_f - sam_f)), 32'd0);

    while (n % 16 != 6) step();
    reset_pulse("mid", 3);
    while (n < 16) step();
    chk("mid_first_sym", 32'(sym_bits), 32'hF);
    chk("mid_first_i", 32'(sam_i), 32'h08000);
    run(20);
    chk("mid_second_sym", 32'(sym_bits), 32'hE);

    for (int r = 0; r < 6; r++) begin
      run($urandom_range(20, 200));
      #($urandom_range(0, 10));
      reset_pulse("rnd", $urandom_range(1, 5));
    end
    run(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
